// File: rtl/spi_register_bank.sv
// SPI mode-0 write target and 5-entry control register bank for pwm_peripheral.
// Define SPI_READBACK_EN to add register readback on cipo; otherwise cipo is tied low.
module spi_register_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       reg_update
);

  localparam int FRAME_W = ADDR_W + 9;
  localparam int HDR_W   = ADDR_W + 1;
  localparam logic [4:0] FRAME_BITS = 5'(FRAME_W);
  localparam logic [4:0] HDR_BITS   = 5'(HDR_W);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic sclk_d, ncs_d;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall, shift_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign shift_en  = sclk_rise & ~ncs_s & ~ncs_fall;

  logic [FRAME_W-1:0] shift_reg;
  logic [4:0]         bit_cnt;
  logic               overflow;

  // Counter saturates at a full frame; any extra edge poisons the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      overflow  <= 1'b0;
    end else if (ncs_fall) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      overflow  <= 1'b0;
    end else if (shift_en) begin
      if (bit_cnt == FRAME_BITS) begin
        overflow <= 1'b1;
      end else begin
        shift_reg <= {shift_reg[FRAME_W-2:0], copi_s};
        bit_cnt   <= bit_cnt + 5'd1;
      end
    end
  end

  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [7:0]        frame_data;
  logic              commit;

  assign frame_rw   = shift_reg[FRAME_W-1];
  assign frame_addr = shift_reg[FRAME_W-2 -: ADDR_W];
  assign frame_data = shift_reg[7:0];
  assign commit     = ncs_rise && (bit_cnt == FRAME_BITS) && !overflow && frame_rw
                      && (int'(frame_addr) < NUM_REGS);

  logic [7:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      reg_update <= 1'b0;
    end else begin
      reg_update <= commit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && (int'(frame_addr) == i)) regs[i] <= frame_data;
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_start;
  logic [7:0]        rd_value;
  logic [7:0]        rd_shift;
  logic              cipo_q;

  // Header completes on this edge, so the address includes the bit arriving now.
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rd_addr   = {shift_reg[ADDR_W-2:0], copi_s};
  assign rd_start  = shift_en && (bit_cnt == HDR_BITS - 5'd1) && !shift_reg[HDR_W-2];

  always_comb begin
    rd_value = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_addr) == i) rd_value = regs[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_shift <= 8'h00;
      cipo_q   <= 1'b0;
    end else if (ncs_s) begin
      rd_shift <= 8'h00;
      cipo_q   <= 1'b0;
    end else if (rd_start) begin
      rd_shift <= rd_value;
    end else if (sclk_fall) begin
      if (bit_cnt >= HDR_BITS && bit_cnt < FRAME_BITS) begin
        cipo_q   <= rd_shift[7];
        rd_shift <= {rd_shift[6:0], 1'b0};
      end else begin
        cipo_q <= 1'b0;
      end
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed plus randomized bench for spi_register_bank against an array-based register model.
// Honours SPI_READBACK_EN to decide what cipo should return on read frames.
module tb_spi_register_bank;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_REGS    = 5;
`ifdef SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic cipo, reg_update;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  spi_register_bank #(.SYNC_STAGES(SYNC_STAGES), .NUM_REGS(NUM_REGS), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .reg_update(reg_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulse_count = 0;
  int expected_pulses = 0;
  logic [7:0] model [NUM_REGS];

  always @(negedge clk) begin
    if (reg_update === 1'b1) pulse_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host side of one frame; sclk runs at f_clk/10 and cipo is sampled just before each rise.
  task automatic applyStimulus(input logic [15:0] word, input int nbits,
                               output logic [7:0] rx, output logic [2:0] upd);
    rx = 8'h00;
    ncs = 1'b0;
    wait_clks(5);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? word[15-i] : 1'($urandom);
      wait_clks(5);
      if (i >= 8 && i < 16) rx = {rx[6:0], cipo};
      sclk = 1'b1;
      wait_clks(5);
      sclk = 1'b0;
    end
    wait_clks(5);
    ncs = 1'b1;
    copi = 1'b0;
    wait_clks(SYNC_STAGES);
    upd[2] = reg_update;
    wait_clks(1);
    upd[1] = reg_update;
    wait_clks(1);
    upd[0] = reg_update;
    wait_clks(4);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word, input int nbits);
    logic [7:0] rx, exp_rx;
    logic [2:0] upd;
    logic [6:0] addr;
    bit commit;
    addr = word[14:8];
    commit = (nbits == 16) && word[15] && (addr < NUM_REGS);
    exp_rx = (READBACK && !word[15] && addr < NUM_REGS) ? model[addr[2:0]] : 8'h00;
    applyStimulus(word, nbits, rx, upd);
    if (commit) begin
      model[addr[2:0]] = word[7:0];
      expected_pulses++;
    end
    checkOutput({tag, " regs"}, 64'(dut_regs()), 64'(model_regs()));
    checkOutput({tag, " reg_update timing"}, 64'(upd), commit ? 64'h2 : 64'h0);
    if (nbits >= 16) checkOutput({tag, " cipo data"}, 64'(rx), 64'(exp_rx));
    checkOutput({tag, " cipo idle"}, 64'(cipo), 64'h0);
  endtask

  initial begin
    logic [15:0] w;
    int nb, kind;
    int pulses_before;

    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    wait_clks(3);
    checkOutput("reset regs", 64'(dut_regs()), 64'h0);
    checkOutput("reset reg_update", 64'(reg_update), 64'h0);
    checkOutput("reset cipo", 64'(cipo), 64'h0);
    rst = 1'b0;
    wait_clks(10);
    checkOutput("post-reset no pulse", 64'(pulse_count), 64'h0);

    run_frame("write 80FF", 16'h80FF, 16);
    run_frame("write 8433", 16'h8433, 16);
    run_frame("short 82AA", 16'h82AA, 15);
    run_frame("long 82AA", 16'h82AA, 17);
    run_frame("bad addr 85AA", 16'h85AA, 16);
    run_frame("read frame 0201", 16'h0201, 16);
    run_frame("b2b 8201", 16'h8201, 16);
    run_frame("b2b 8302", 16'h8302, 16);
    run_frame("write 8155", 16'h8155, 16);
    run_frame("rewrite 8155", 16'h8155, 16);
    run_frame("read 0100", 16'h0100, 16);
    run_frame("read 7F00", 16'h7F00, 16);

    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 9));
      w[15]   = (kind < 6) ? 1'b1 : 1'b0;
      w[14:8] = (kind == 9) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 7));
      w[7:0]  = 8'($urandom);
      case (kind)
        7: nb = int'($urandom_range(10, 15));
        8: nb = int'($urandom_range(17, 20));
        default: nb = 16;
      endcase
      run_frame($sformatf("random %0d w=%h n=%0d", n, w, nb), w, nb);
    end

    // Abort a frame halfway with an asynchronous reset, then finish clocking it out.
    pulses_before = pulse_count;
    ncs = 1'b0;
    wait_clks(5);
    for (int i = 0; i < 6; i++) begin
      copi = (i == 0) ? 1'b1 : 1'b0;
      wait_clks(5); sclk = 1'b1; wait_clks(5); sclk = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    checkOutput("async reset regs", 64'(dut_regs()), 64'h0);
    checkOutput("async reset reg_update", 64'(reg_update), 64'h0);
    checkOutput("async reset cipo", 64'(cipo), 64'h0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    for (int i = 0; i < 10; i++) begin
      copi = 1'b1;
      wait_clks(5); sclk = 1'b1; wait_clks(5); sclk = 1'b0;
    end
    wait_clks(5);
    ncs = 1'b1;
    wait_clks(10);
    checkOutput("aborted frame regs", 64'(dut_regs()), 64'h0);
    checkOutput("aborted frame pulses", 64'(pulse_count - pulses_before), 64'h0);

    run_frame("after reset 8499", 16'h8499, 16);
    pulses_before = pulses_before + 1;
    checkOutput("total pulses", 64'(pulse_count), 64'(expected_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
